btn_event_decoder: RTL and testbench



---
 rtl/btn_evt_pkg.sv | 30 +++
 rtl/btn_event_fsm.sv | 120 ++++++++++++
 rtl/btn_event_decoder.sv | 60 ++++++
 tb/tb_btn_event_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event decoder.
// Optional auto-repeat is enabled by defining BTN_EVT_REPEAT_EN.
package btn_evt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int w;
      int v;
      w = 0;
      v = n - 1;
      while (v > 0) begin
         w = w + 1;
         v = v >> 1;
      end
      return w;
   endfunction

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// One button: IDLE/PRESSED/HELD classifier with registered event pulses.
// BTN_EVT_REPEAT_EN adds the auto-repeat counter in HELD.
module btn_event_fsm
   import btn_evt_pkg::*;
#(
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic level,
   input  logic rise,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic btn_held
);

`ifdef BTN_EVT_REPEAT_EN
   localparam int CNT_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
`else
   localparam int CNT_MAX = LONG_MS;
`endif
   localparam int CW = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
`ifdef BTN_EVT_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_MS - 1);
`endif

   state_t        state;
   state_t        state_d;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_d;
   logic          short_d;
   logic          long_d;
`ifdef BTN_EVT_REPEAT_EN
   logic          rep_d;
`endif

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      short_d = 1'b0;
      long_d  = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rep_d   = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            // A tick coinciding with the press edge is deliberately not counted
            if (rise) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end
         end
         ST_PRESSED: begin
            if (!level) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               short_d = 1'b1;
            end else if (tick) begin
               if (cnt == LONG_LAST) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
                  long_d  = 1'b1;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         ST_HELD: begin
            if (!level) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
`ifdef BTN_EVT_REPEAT_EN
            else if (tick) begin
               if (cnt == REP_LAST) begin
                  cnt_d = '0;
                  rep_d = 1'b1;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
         btn_held    <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         short_pulse <= short_d;
         long_pulse  <= long_d;
         btn_held    <= (state_d == ST_HELD);
      end
   end

`ifdef BTN_EVT_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) repeat_pulse <= 1'b0;
      else     repeat_pulse <= rep_d;
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced button presses into SHORT/LONG/REPEAT pulses.
// Auto-repeat is built only when BTN_EVT_REPEAT_EN is defined.
module btn_event_decoder
   import btn_evt_pkg::*;
#(
   parameter int BTN_WIDTH = 4,
   parameter int PRESCALE  = 6000,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BTN_WIDTH-1:0] btn_level,
   output logic [BTN_WIDTH-1:0] short_pulse,
   output logic [BTN_WIDTH-1:0] long_pulse,
   output logic [BTN_WIDTH-1:0] repeat_pulse,
   output logic [BTN_WIDTH-1:0] btn_held
);

   localparam int PW = cnt_width(PRESCALE - 1);
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]        ps_cnt;
   logic                 tick;
   logic [BTN_WIDTH-1:0] prev;
   logic [BTN_WIDTH-1:0] rise;

   assign tick = (ps_cnt == PS_LAST);

   always_ff @(posedge clk) begin
      if (rst || tick) ps_cnt <= '0;
      else             ps_cnt <= ps_cnt + 1'b1;
   end

   // prev resets high so a button held through reset needs a fresh press
   always_ff @(posedge clk) begin
      if (rst) prev <= '1;
      else     prev <= btn_level;
   end

   assign rise = btn_level & ~prev;

   for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
      btn_event_fsm #(
         .LONG_MS   (LONG_MS),
         .REPEAT_MS (REPEAT_MS)
      ) u_fsm (
         .clk          (clk),
         .rst          (rst),
         .tick         (tick),
         .level        (btn_level[i]),
         .rise         (rise[i]),
         .short_pulse  (short_pulse[i]),
         .long_pulse   (long_pulse[i]),
         .repeat_pulse (repeat_pulse[i]),
         .btn_held     (btn_held[i])
      );
   end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench for btn_event_decoder (PRESCALE=4, LONG_MS=5, REPEAT_MS=2).
// Repeat expectations follow BTN_EVT_REPEAT_EN.
module tb_btn_event_decoder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] btn_level = '0;
   logic [W-1:0] short_pulse;
   logic [W-1:0] long_pulse;
   logic [W-1:0] repeat_pulse;
   logic [W-1:0] btn_held;

   always #5 clk = ~clk;

   btn_event_decoder #(
      .BTN_WIDTH (W),
      .PRESCALE  (4),
      .LONG_MS   (5),
      .REPEAT_MS (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_level    (btn_level),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .btn_held     (btn_held)
   );

   typedef struct {
      int         cyc;
      logic [3:0] s;
      logic [3:0] l;
      logic [3:0] r;
   } ev_t;

   ev_t q[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  ph = 0;

   // cyc counts clock edges; ph tracks the prescaler phase (tick when ph==3)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) ph <= 0;
      else     ph <= (ph == 3) ? 0 : ph + 1;
   end

   task automatic expect_ev(input int c, input logic [3:0] s,
                            input logic [3:0] l, input logic [3:0] r);
      ev_t e;
      e.cyc = c;
      e.s = s;
      e.l = l;
      e.r = r;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic align();
      while (ph != 0) step(1);
   endtask

   task automatic check(input string name, input logic [3:0] act,
                        input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      if ((short_pulse | long_pulse | repeat_pulse) != '0) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: cyc=%0d s=%b l=%b r=%b",
                     cyc, short_pulse, long_pulse, repeat_pulse);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.s !== short_pulse ||
                e.l !== long_pulse || e.r !== repeat_pulse) begin
               bad++;
               $display("FAIL event: got cyc=%0d s=%b l=%b r=%b want cyc=%0d s=%b l=%b r=%b",
                        cyc, short_pulse, long_pulse, repeat_pulse,
                        e.cyc, e.s, e.l, e.r);
            end
         end
      end
   end

   initial begin
      int c;
      step(3);
      check("rst_short", short_pulse, 4'b0000);
      check("rst_long", long_pulse, 4'b0000);
      check("rst_repeat", repeat_pulse, 4'b0000);
      check("rst_held", btn_held, 4'b0000);
      rst = 1'b0;
      step(2);

      // short press of btn0 for 3 ticks
      align();
      btn_level[0] = 1'b1;
      step(12);
      btn_level[0] = 1'b0;
      expect_ev(cyc + 1, 4'b0001, 4'b0000, 4'b0000);
      step(10);

      // long hold of btn1 with auto-repeat
      align();
      c = cyc;
      btn_level[1] = 1'b1;
      expect_ev(c + 20, 4'b0000, 4'b0010, 4'b0000);
`ifdef BTN_EVT_REPEAT_EN
      for (int k = 28; k <= 44; k += 8)
         expect_ev(c + k, 4'b0000, 4'b0000, 4'b0010);
`endif
      step(21);
      check("held_btn1", btn_held, 4'b0010);
      step(25);
      btn_level[1] = 1'b0;
      step(2);
      check("held_btn1_off", btn_held, 4'b0000);
      step(10);

      // btn0 and btn2 together: short on 0, long on 2
      align();
      c = cyc;
      btn_level = 4'b0101;
      step(8);
      btn_level[0] = 1'b0;
      expect_ev(cyc + 1, 4'b0001, 4'b0000, 4'b0000);
      expect_ev(c + 20, 4'b0000, 4'b0100, 4'b0000);
      step(18);
      btn_level[2] = 1'b0;
      step(10);

      // release coincides with the 5th tick: SHORT wins
      align();
      c = cyc;
      btn_level[0] = 1'b1;
      step(19);
      btn_level[0] = 1'b0;
      expect_ev(c + 20, 4'b0001, 4'b0000, 4'b0000);
      step(10);

      // press sampled on a tick edge: that tick is not counted
      align();
      step(3);
      c = cyc;
      btn_level[1] = 1'b1;
      expect_ev(c + 21, 4'b0000, 4'b0010, 4'b0000);
      step(23);
      btn_level[1] = 1'b0;
      step(10);

      // reset while btn3 is HELD and still pressed
      align();
      c = cyc;
      btn_level[3] = 1'b1;
      expect_ev(c + 20, 4'b0000, 4'b1000, 4'b0000);
      step(22);
      check("held_btn3", btn_held, 4'b1000);
      rst = 1'b1;
      step(1);
      check("mid_rst_short", short_pulse, 4'b0000);
      check("mid_rst_long", long_pulse, 4'b0000);
      check("mid_rst_repeat", repeat_pulse, 4'b0000);
      check("mid_rst_held", btn_held, 4'b0000);
      rst = 1'b0;
      step(60);
      check("held_after_rst", btn_held, 4'b0000);
      btn_level[3] = 1'b0;
      step(3);
      align();
      btn_level[3] = 1'b1;
      step(6);
      btn_level[3] = 1'b0;
      expect_ev(cyc + 1, 4'b1000, 4'b0000, 4'b0000);
      step(10);

      // btn2 held for 20 ticks
      align();
      c = cyc;
      btn_level[2] = 1'b1;
      expect_ev(c + 20, 4'b0000, 4'b0100, 4'b0000);
`ifdef BTN_EVT_REPEAT_EN
      for (int k = 28; k <= 76; k += 8)
         expect_ev(c + k, 4'b0000, 4'b0000, 4'b0100);
`endif
      step(80);
      check("held_btn2", btn_held, 4'b0100);
      btn_level[2] = 1'b0;
      step(10);

      while (q.size() != 0) begin
         ev_t e;
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_event: want cyc=%0d s=%b l=%b r=%b",
                  e.cyc, e.s, e.l, e.r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
